// File: rtl/mxv_pkg.sv
// Shared definitions for the matrix-vector sequencer and the command parser.
package mxv_pkg;

  localparam int unsigned MAX_N = 8;
  localparam int unsigned MIN_N = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MAC,
    ST_STORE,
    ST_SEND,
    ST_DONE,
    ST_ERR
  } mxv_state_t;

endpackage

// File: rtl/mxv_index_counter.sv
// Index counter with clear, enable and a programmable terminal value.
// Wraps to zero when enabled at the terminal value so it never exceeds it.
module mxv_index_counter #(
  parameter int unsigned Word_Length = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [Word_Length-1:0] terminal,
  output logic [Word_Length-1:0] count,
  output logic                   last
);

  assign last = (count == terminal);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= last ? '0 : count + Word_Length'(1);
    end
  end

endmodule

// File: rtl/mxv_sequencer.sv
// Control sequencer for y = M*v: drives FIFO pops, MAC strobes, result
// writes and result transmission, with resend, abort and error handling.
module mxv_sequencer
  import mxv_pkg::*;
#(
  parameter int unsigned Word_Length = 8,
  parameter int unsigned MAX_N       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   resend,
  input  logic                   abort,
  input  logic [Word_Length-1:0] matrix_size,
  input  logic                   fifo_empty,
  input  logic                   tx_ready,
  output logic                   pop,
  output logic                   mac_clear,
  output logic                   mac_en,
  output logic [Word_Length-1:0] col_index,
  output logic                   result_we,
  output logic [Word_Length-1:0] row_index,
  output logic                   tx_valid,
  output logic [Word_Length-1:0] tx_index,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  mxv_state_t state_q, state_d;

  logic [Word_Length-1:0] n_q;
  logic [Word_Length-1:0] terminal;
  logic                   results_valid;
  logic                   size_ok;

  logic n_load, rv_set, rv_clr;
  logic col_clr, col_en, col_last;
  logic row_clr, row_en, row_last;
  logic tx_clr, tx_en, tx_last;
  logic [Word_Length-1:0] col_cnt, row_cnt, tx_cnt;

  logic pop_s, mac_clear_s, mac_en_s, result_we_s, tx_valid_s, done_s, error_s;

  assign terminal = n_q - Word_Length'(1);
  assign size_ok  = (matrix_size >= Word_Length'(MIN_N)) &&
                    (matrix_size <= Word_Length'(MAX_N));

  mxv_index_counter #(.Word_Length(Word_Length)) u_col (
    .clk(clk), .reset(reset), .clear(col_clr), .enable(col_en),
    .terminal(terminal), .count(col_cnt), .last(col_last)
  );

  mxv_index_counter #(.Word_Length(Word_Length)) u_row (
    .clk(clk), .reset(reset), .clear(row_clr), .enable(row_en),
    .terminal(terminal), .count(row_cnt), .last(row_last)
  );

  mxv_index_counter #(.Word_Length(Word_Length)) u_tx (
    .clk(clk), .reset(reset), .clear(tx_clr), .enable(tx_en),
    .terminal(terminal), .count(tx_cnt), .last(tx_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      n_q           <= '0;
      results_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (n_load) n_q <= matrix_size;
      if (rv_clr) results_valid <= 1'b0;
      else if (rv_set) results_valid <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_load      = 1'b0;
    rv_set      = 1'b0;
    rv_clr      = 1'b0;
    col_clr     = 1'b0;
    col_en      = 1'b0;
    row_clr     = 1'b0;
    row_en      = 1'b0;
    tx_clr      = 1'b0;
    tx_en       = 1'b0;
    pop_s       = 1'b0;
    mac_clear_s = 1'b0;
    mac_en_s    = 1'b0;
    result_we_s = 1'b0;
    tx_valid_s  = 1'b0;
    done_s      = 1'b0;
    error_s     = 1'b0;

    // Abort outranks every transition and silences all strobes this cycle.
    if (state_q != ST_IDLE && abort) begin
      state_d = ST_IDLE;
      col_clr = 1'b1;
      row_clr = 1'b1;
      tx_clr  = 1'b1;
      rv_clr  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (size_ok) begin
              n_load  = 1'b1;
              row_clr = 1'b1;
              col_clr = 1'b1;
              state_d = ST_CLEAR;
            end else begin
              state_d = ST_ERR;
            end
          end else if (resend) begin
            if (results_valid) begin
              tx_clr  = 1'b1;
              state_d = ST_SEND;
            end else begin
              state_d = ST_ERR;
            end
          end
        end
        ST_CLEAR: begin
          mac_clear_s = 1'b1;
          col_clr     = 1'b1;
          state_d     = ST_MAC;
        end
        ST_MAC: begin
          if (!fifo_empty) begin
            pop_s    = 1'b1;
            mac_en_s = 1'b1;
            col_en   = 1'b1;
            if (col_last) state_d = ST_STORE;
          end
        end
        ST_STORE: begin
          result_we_s = 1'b1;
          row_en      = 1'b1;
          if (row_last) begin
            tx_clr  = 1'b1;
            rv_set  = 1'b1;
            state_d = ST_SEND;
          end else begin
            state_d = ST_CLEAR;
          end
        end
        ST_SEND: begin
          tx_valid_s = 1'b1;
          if (tx_ready) begin
            tx_en = 1'b1;
            if (tx_last) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_ERR: begin
          error_s = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Gating with reset keeps every output low while reset is held, even
  // before the first clock edge has initialised the state register.
  assign pop       = reset & pop_s;
  assign mac_clear = reset & mac_clear_s;
  assign mac_en    = reset & mac_en_s;
  assign result_we = reset & result_we_s;
  assign tx_valid  = reset & tx_valid_s;
  assign done      = reset & done_s;
  assign error     = reset & error_s;
  assign busy      = reset & (state_q != ST_IDLE);
  assign col_index = reset ? col_cnt : '0;
  assign row_index = reset ? row_cnt : '0;
  assign tx_index  = reset ? tx_cnt  : '0;

endmodule

// File: doc/mxv_sequencer.md
MXV_SEQUENCER -- requirements
Module: mxv_sequencer

Interface
REQ-001 Parameter Word_Length, default 8: width of matrix_size and all index outputs.
REQ-002 Parameter MAX_N, default 8: largest legal matrix dimension.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 start  input  1  single-cycle request to compute y = M*v from the loaded FIFO/vector.
REQ-006 resend  input  1  single-cycle request to retransmit the last result set.
REQ-007 abort  input  1  cancel any operation in progress.
REQ-008 matrix_size  input  Word_Length  dimension N; sampled only on an accepted start.
REQ-009 fifo_empty  input  1  matrix FIFO has no element.
REQ-010 tx_ready  input  1  result transmitter can accept a byte.
REQ-011 pop  output  1  pop one matrix element from the FIFO this cycle.
REQ-012 mac_clear  output  1  zero the accumulator.
REQ-013 mac_en  output  1  accumulate FIFO head times vector[col_index].
REQ-014 col_index  output  Word_Length  vector element selected for the current MAC.
REQ-015 result_we  output  1  write the accumulator to result[row_index].
REQ-016 row_index  output  Word_Length  current matrix row / result slot.
REQ-017 tx_valid  output  1  result[tx_index] is offered to the transmitter.
REQ-018 tx_index  output  Word_Length  result slot being sent.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse when the last result byte is accepted.
REQ-021 error  output  1  one-cycle pulse on a rejected request.

Function
REQ-022 FSM states: IDLE, CLEAR, MAC, STORE, SEND, DONE, ERR.
REQ-023 IDLE: start with 1<=matrix_size<=MAX_N latches N, clears row, goes to CLEAR; start with any other N goes to ERR.
REQ-024 IDLE: resend (start low) goes to SEND with tx_index=0 if results_valid=1, else to ERR.
REQ-025 start and resend in the same cycle: start wins and resend is dropped.
REQ-026 start and resend outside IDLE are ignored, with no queuing.
REQ-027 CLEAR: mac_clear=1 for exactly one cycle, col=0, then MAC.
REQ-028 MAC with fifo_empty=1: stall with pop=0 and mac_en=0, holding col.
REQ-029 MAC with fifo_empty=0: pop=1 and mac_en=1 in the same cycle, col_index=col, col increments.
REQ-030 MAC: a pop at col==N-1 moves to STORE.
REQ-031 STORE: result_we=1 for one cycle at row_index, then row increments.
REQ-032 STORE: if row==N-1, go to SEND with tx_index=0 and set results_valid=1; otherwise go to CLEAR.
REQ-033 Latency without stalls: first mac_clear in the cycle after start; the last result_we occurs N*(N+2) cycles after the cycle that accepted start.
REQ-034 SEND: tx_valid=1 and tx_index stable until tx_ready=1; a byte transfers on tx_valid&tx_ready.
REQ-035 SEND: on a transfer, tx_index increments; the transfer at tx_index==N-1 moves to DONE.
REQ-036 DONE: done=1 for one cycle, then IDLE.
REQ-037 ERR: error=1 for one cycle, then IDLE; N, row and results_valid are unchanged.
REQ-038 abort in any non-IDLE state: IDLE next cycle with all strobes low that cycle, results_valid=0 and counters zeroed.
REQ-039 abort in IDLE has no effect; abort takes priority over every other transition.
REQ-040 pop, mac_en, mac_clear, result_we, tx_valid, done and error are decoded from state and inputs only.
REQ-041 pop is never asserted while fifo_empty=1.
REQ-042 All index counters are Word_Length bits wide and never exceed N-1.

Reset
REQ-043 reset=0 at a clock edge forces IDLE and zeroes N, col, row, tx_index and results_valid.
REQ-044 While in reset, every output is 0, including busy.
REQ-045 reset asserted mid-operation discards the partial computation; no done or error is produced.

Structure
REQ-046 Shared package mxv_pkg holds the state enum, MAX_N and MIN_N=1, shared with the command parser.
REQ-047 One sub-module, mxv_index_counter, is instantiated three times for col, row and tx_index; it provides clear, enable, a programmable terminal value and a last flag.

Verification
REQ-048 N=2, FIFO never empty, tx_ready=1: start -> sequence clr,mac,mac,store,clr,mac,mac,store; 4 pops; 2 tx transfers; done on cycle 11.
REQ-049 N=3 with fifo_empty high for 3 cycles mid-row 1: no pop while empty; total pops 9; row_index order 0,1,2.
REQ-050 start with matrix_size=0, then again with 9: error pulse each time; busy stays 0 except one ERR cycle.
REQ-051 resend after reset: error pulse; after a completed N=2 run, resend -> 2 transfers with tx_index 0,1, then done.
REQ-052 tx_ready low for 5 cycles while in SEND: tx_valid held and tx_index stable, no advance.
REQ-053 abort during MAC of N=4 row 2, and a separate reset=0 during STORE: IDLE next edge, no done, and a later resend gives error.
